// File: rtl/ipc_sched_pkg.sv
// Shared types and helpers for the IPC pulse channel scheduler.
package ipc_sched_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SILK_WAIT,
        S_ARM,
        S_ON,
        S_OFF,
        S_HOLD
    } sched_state_e;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/sched_rr_pick.sv
// Round-robin next-channel pick: first enabled channel strictly after last_ch.
module sched_rr_pick
    import ipc_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [CH_W-1:0]   last_ch,
    output logic [CH_W-1:0]   next_ch,
    output logic              valid
);

    logic [CH_W-1:0] cand;

    // Scan from farthest to nearest so the nearest enabled channel wins;
    // offset NUM_CH wraps back onto last_ch itself (single-channel case).
    always_comb begin
        next_ch = last_ch;
        valid   = 1'b0;
        cand    = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = last_ch + CH_W'(i);
            if (ch_en[cand]) begin
                next_ch = cand;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_channel_sched.sv
// Round-robin discharge pulse scheduler with short-circuit abort and recovery.
// Optional statistics counters enabled by defining PULSE_SCHED_STATS_EN.
module pulse_channel_sched
    import ipc_sched_pkg::*;
#(
    parameter int unsigned            CNT_W       = 16,
    parameter logic [CNT_W-1:0]       SHORT_EXTRA = CNT_W'(500)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                power_start,
    input  logic                silk_reach,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic [CNT_W-1:0]    ton,
    input  logic [CNT_W-1:0]    ts,
    input  logic                short_flag,
    output logic [NUM_CH-1:0]   fire,
    output logic [CH_W-1:0]     active_ch,
    output logic                busy,
    output logic                short_evt,
    output logic [CNT_W-1:0]    pulse_cnt,
    output logic [CNT_W-1:0]    short_cnt
);

    sched_state_e      state_q, state_d, exit_state;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  ts_q, ts_d;
    logic [CH_W-1:0]   last_ch_q, last_ch_d;
    logic [CH_W-1:0]   active_ch_q, active_ch_d;
    logic [NUM_CH-1:0] fire_q, fire_d;
    logic              short_evt_q, short_evt_d;

    logic [CH_W-1:0]   pick_ch;
    logic              pick_valid;
    logic [CNT_W-1:0]  ton_eff, ts_eff, hold_len;
    logic [CNT_W:0]    hold_sum;
    logic              cnt_last;

    sched_rr_pick u_pick (
        .ch_en   (ch_en),
        .last_ch (last_ch_q),
        .next_ch (pick_ch),
        .valid   (pick_valid)
    );

    assign ton_eff  = (ton == '0) ? CNT_W'(1) : ton;
    assign ts_eff   = (ts  == '0) ? CNT_W'(1) : ts;
    // Recovery time saturates rather than wrapping to a short off-time.
    assign hold_sum = {1'b0, ts_q} + {1'b0, SHORT_EXTRA};
    assign hold_len = hold_sum[CNT_W] ? '1 : hold_sum[CNT_W-1:0];
    assign cnt_last = (cnt_q == CNT_W'(1));

    always_comb begin
        if (power_start && silk_reach && (ch_en != '0)) exit_state = S_ARM;
        else if (power_start)                           exit_state = S_SILK_WAIT;
        else                                            exit_state = S_IDLE;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ts_d        = ts_q;
        last_ch_d   = last_ch_q;
        active_ch_d = active_ch_q;
        short_evt_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (power_start && (ch_en != '0)) state_d = S_SILK_WAIT;
            end
            S_SILK_WAIT: begin
                if (silk_reach)        state_d = S_ARM;
                else if (!power_start) state_d = S_IDLE;
            end
            S_ARM: begin
                if (!power_start || !pick_valid) begin
                    state_d = S_IDLE;
                end else begin
                    state_d     = S_ON;
                    cnt_d       = ton_eff;
                    ts_d        = ts_eff;
                    last_ch_d   = pick_ch;
                    active_ch_d = pick_ch;
                end
            end
            S_ON: begin
                // Short beats both the terminal count and a power drop.
                if (short_flag) begin
                    state_d     = S_HOLD;
                    cnt_d       = hold_len;
                    short_evt_d = 1'b1;
                end else if (!power_start || cnt_last) begin
                    state_d = S_OFF;
                    cnt_d   = ts_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_OFF, S_HOLD: begin
                if (cnt_last) state_d = exit_state;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // fire is a flop driven from the next state, so it is glitch-free and aligned with ON.
    assign fire_d = (state_d == S_ON) ? ch_onehot(active_ch_d) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ts_q        <= '0;
            last_ch_q   <= CH_W'(NUM_CH - 1);
            active_ch_q <= '0;
            fire_q      <= '0;
            short_evt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ts_q        <= ts_d;
            last_ch_q   <= last_ch_d;
            active_ch_q <= active_ch_d;
            fire_q      <= fire_d;
            short_evt_q <= short_evt_d;
        end
    end

    assign fire      = fire_q;
    assign active_ch = active_ch_q;
    assign busy      = (state_q != S_IDLE);
    assign short_evt = short_evt_q;

`ifdef PULSE_SCHED_STATS_EN
    logic [CNT_W-1:0] pulse_cnt_q, short_cnt_q;
    logic             pulse_done, short_done;

    assign pulse_done = (state_q == S_ON) && (state_d == S_OFF);
    assign short_done = (state_q == S_ON) && (state_d == S_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_cnt_q <= '0;
            short_cnt_q <= '0;
        end else begin
            if (pulse_done) pulse_cnt_q <= pulse_cnt_q + CNT_W'(1);
            if (short_done) short_cnt_q <= short_cnt_q + CNT_W'(1);
        end
    end

    assign pulse_cnt = pulse_cnt_q;
    assign short_cnt = short_cnt_q;
`else
    assign pulse_cnt = '0;
    assign short_cnt = '0;
`endif

endmodule

// File: tb/tb_pulse_channel_sched.sv
// Scoreboard bench for pulse_channel_sched: a pulse-level model predicts each
// pulse (channel, width, preceding gap, short abort); a monitor checks them.
module tb_pulse_channel_sched;

    localparam int EXTRA = 500;
    localparam int LIM   = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        power_start = 1'b0;
    logic        silk_reach = 1'b0;
    logic        short_flag = 1'b0;
    logic [3:0]  ch_en = 4'b0;
    logic [15:0] ton = 16'd0;
    logic [15:0] ts = 16'd0;
    logic [3:0]  fire;
    logic [1:0]  active_ch;
    logic        busy;
    logic        short_evt;
    logic [15:0] pulse_cnt;
    logic [15:0] short_cnt;

    pulse_channel_sched #(.CNT_W(16), .SHORT_EXTRA(16'd500)) dut (
        .clk(clk), .rst_n(rst_n), .power_start(power_start), .silk_reach(silk_reach),
        .ch_en(ch_en), .ton(ton), .ts(ts), .short_flag(short_flag),
        .fire(fire), .active_ch(active_ch), .busy(busy), .short_evt(short_evt),
        .pulse_cnt(pulse_cnt), .short_cnt(short_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int width;
        int gap;
        bit shorted;
    } pulse_t;

    pulse_t exp_q[$];
    int compared = 0, mismatched = 0;
    int model_last = 3, exp_pulse_cnt = 0, exp_short_cnt = 0;
    int mark_seq = 0;
    int stray_evt = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        compared++;
        mismatched++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    function automatic int rr_next(input logic [3:0] en, input int last);
        for (int i = 1; i <= 4; i++)
            if (en[(last + i) % 4]) return (last + i) % 4;
        return last;
    endfunction

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int hold_len(input int tsv);
        int s;
        s = eff(tsv) + EXTRA;
        return (s > 65535) ? 65535 : s;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_fire(input bit high, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < LIM; i++) begin
            if ((fire != 4'b0) == high) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) timeout(nm);
    endtask

    task automatic measure_tail(input int exp_tail, input string nm);
        int cnt;
        cnt = 0;
        while (busy && cnt < 70000) begin
            step();
            cnt++;
        end
        check(nm, cnt, exp_tail);
    endtask

    task automatic check_stats(input string nm);
`ifdef PULSE_SCHED_STATS_EN
        check({nm, "_pulse_cnt"}, pulse_cnt, exp_pulse_cnt % 65536);
        check({nm, "_short_cnt"}, short_cnt, exp_short_cnt % 65536);
`else
        check({nm, "_pulse_cnt"}, pulse_cnt, 0);
        check({nm, "_short_cnt"}, short_cnt, 0);
`endif
        check({nm, "_pending"}, exp_q.size(), 0);
    endtask

    // kind: 0 none, 1 short on pulse ak at ON cycle aj, 2 power drop on last pulse at ON cycle aj
    task automatic run_phase(input string nm, input logic [3:0] en, input int ton_v, input int ts_v,
                             input int n, input int kind, input int ak, input int aj);
        pulse_t p;
        bit prev_short;
        int tail;
        prev_short = 1'b0;
        for (int k = 0; k < n; k++) begin
            p.ch      = rr_next(en, model_last);
            model_last = p.ch;
            p.width   = (kind != 0 && k == ak) ? aj : eff(ton_v);
            p.gap     = (k == 0) ? 3 : (prev_short ? hold_len(ts_v) + 1 : eff(ts_v) + 1);
            p.shorted = (kind == 1 && k == ak);
            prev_short = p.shorted;
            if (p.shorted) exp_short_cnt++;
            else           exp_pulse_cnt++;
            exp_q.push_back(p);
        end
        tail = prev_short ? hold_len(ts_v) : eff(ts_v);

        ch_en = en; ton = 16'(ton_v); ts = 16'(ts_v); silk_reach = 1'b1;
        mark_seq++;
        power_start = 1'b1;
        for (int k = 0; k < n; k++) begin
            wait_fire(1'b1, {nm, "_rise"});
            if (kind != 0 && k == ak) begin
                repeat (aj - 1) step();
                if (kind == 1) short_flag = 1'b1;
                else           power_start = 1'b0;
                step();
                short_flag = 1'b0;
            end
            wait_fire(1'b0, {nm, "_fall"});
        end
        power_start = 1'b0;
        measure_tail(tail, {nm, "_tail"});
        step();
        check_stats(nm);
    endtask

    // Monitor: pops one expectation per observed pulse, checks it on the way in and out.
    initial begin : monitor
        int low_cnt, width, seen_mark;
        logic [3:0] cur;
        bit in_pulse;
        pulse_t e;
        low_cnt = 0; width = 0; seen_mark = 0; cur = 4'b0; in_pulse = 1'b0;
        e = '{ch: -1, width: -1, gap: -1, shorted: 1'b0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_pulse = 1'b0;
                low_cnt  = 0;
                continue;
            end
            if (seen_mark != mark_seq) begin
                seen_mark = mark_seq;
                low_cnt   = 0;
            end
            if (fire != 4'b0 && !in_pulse) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", fire, 0);
                    e = '{ch: -1, width: -1, gap: -1, shorted: 1'b0};
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_ch", fire, 4'b1 << e.ch);
                    check("active_ch", active_ch, e.ch);
                    check("gap", low_cnt, e.gap);
                end
                in_pulse = 1'b1;
                cur      = fire;
                width    = 1;
                if (short_evt) stray_evt++;
            end else if (in_pulse && fire != 4'b0) begin
                check("fire_stable", fire, cur);
                width++;
                if (short_evt) stray_evt++;
            end else if (in_pulse) begin
                check("width", width, e.width);
                check("short_evt", short_evt, e.shorted);
                in_pulse = 1'b0;
                low_cnt  = 1;
            end else begin
                low_cnt++;
                if (short_evt) stray_evt++;
            end
        end
    end

    initial begin : driver
        int en, tv, sv, n, kind, ak, aj;
        repeat (3) step();
        check("rst_fire", fire, 0);
        check("rst_active_ch", active_ch, 0);
        check("rst_busy", busy, 0);
        check("rst_short_evt", short_evt, 0);
        check("rst_pulse_cnt", pulse_cnt, 0);
        check("rst_short_cnt", short_cnt, 0);
        rst_n = 1'b1;
        step();

        run_phase("rotation", 4'b1111, 10, 20, 5, 0, 0, 0);
        run_phase("sparse", 4'b1010, 5, 5, 4, 0, 0, 0);
        run_phase("short", 4'b1111, 10, 20, 3, 1, 1, 4);
        run_phase("short_tc", 4'b1111, 6, 3, 2, 1, 0, 6);
        run_phase("zero", 4'b1111, 0, 0, 4, 0, 0, 0);
        run_phase("stop", 4'b0110, 12, 7, 2, 2, 1, 5);

        // Silk loss mid-pulse: pulse completes, parks in SILK_WAIT, resumes 2 cycles after re-raise.
        begin
            pulse_t p;
            p.ch = rr_next(4'b1111, model_last); model_last = p.ch;
            p.width = 8; p.gap = 3; p.shorted = 1'b0;
            exp_q.push_back(p);
            p.ch = rr_next(4'b1111, model_last); model_last = p.ch;
            p.gap = 2;
            exp_q.push_back(p);
            exp_pulse_cnt += 2;
            ch_en = 4'b1111; ton = 16'd8; ts = 16'd6; silk_reach = 1'b1;
            mark_seq++;
            power_start = 1'b1;
            wait_fire(1'b1, "silk_rise0");
            repeat (2) step();
            silk_reach = 1'b0;
            wait_fire(1'b0, "silk_fall0");
            repeat (16) step();
            check("silk_wait_busy", busy, 1);
            mark_seq++;
            silk_reach = 1'b1;
            wait_fire(1'b1, "silk_rise1");
            wait_fire(1'b0, "silk_fall1");
            power_start = 1'b0;
            measure_tail(6, "silk_tail");
            step();
            check_stats("silk");
        end

        for (int r = 0; r < 6; r++) begin
            en   = $urandom_range(1, 15);
            tv   = $urandom_range(0, 12);
            sv   = $urandom_range(0, 12);
            n    = $urandom_range(1, 5);
            kind = $urandom_range(0, 2);
            ak   = (kind == 2) ? n - 1 : $urandom_range(0, n - 1);
            aj   = $urandom_range(1, eff(tv));
            run_phase("random", 4'(en), tv, sv, n, kind, ak, aj);
        end

        // Asynchronous reset mid-pulse clears everything at once; next start picks ch0.
        begin
            pulse_t p;
            p.ch = rr_next(4'b1111, model_last);
            p.width = 20; p.gap = 3; p.shorted = 1'b0;
            exp_q.push_back(p);
            ch_en = 4'b1111; ton = 16'd20; ts = 16'd5; silk_reach = 1'b1;
            mark_seq++;
            power_start = 1'b1;
            wait_fire(1'b1, "reset_rise");
            repeat (5) step();
            rst_n = 1'b0;
            #1;
            check("arst_fire", fire, 0);
            check("arst_busy", busy, 0);
            check("arst_active_ch", active_ch, 0);
            check("arst_short_evt", short_evt, 0);
            check("arst_pulse_cnt", pulse_cnt, 0);
            check("arst_short_cnt", short_cnt, 0);
            model_last = 3; exp_pulse_cnt = 0; exp_short_cnt = 0;
            power_start = 1'b0;
            repeat (2) step();
            rst_n = 1'b1;
            step();
        end
        run_phase("post_reset", 4'b1111, 4, 3, 2, 0, 0, 0);

        run_phase("saturate", 4'b1111, 5, 16'hFFFF, 1, 1, 0, 2);

        check("stray_short_evt", stray_evt, 0);
        check("final_pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
